// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_pkg
//  Purpose  : Shared definitions for the Game scoreboard: the Game state
//             codes, the reward/prompt masks, the ending codes and the
//             scoreboard FSM state type.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Game adventure state codes
    localparam logic [4:0] ST_START     = 5'd1;
    localparam logic [4:0] ST_CHOICE_A  = 5'd2;
    localparam logic [4:0] ST_STUDY     = 5'd3;
    localparam logic [4:0] ST_EXERCISE  = 5'd4;
    localparam logic [4:0] ST_SLEEP     = 5'd5;
    localparam logic [4:0] ST_CHOICE_B  = 5'd6;
    localparam logic [4:0] ST_HELP      = 5'd7;
    localparam logic [4:0] ST_WANDER    = 5'd8;
    localparam logic [4:0] ST_SUCCESS   = 5'd9;
    localparam logic [4:0] ST_DROPOUT   = 5'd10;
    localparam logic [4:0] ST_CHOICE_C  = 5'd11;
    localparam logic [4:0] ST_CHOICE_D  = 5'd12;
    localparam logic [4:0] ST_BURNOUT   = 5'd13;
    localparam logic [4:0] ST_READ      = 5'd14;
    localparam logic [4:0] ST_NAP       = 5'd15;
    localparam logic [4:0] ST_REPEAT    = 5'd16;
    localparam logic [4:0] ST_PRACTICE  = 5'd17;
    localparam logic [4:0] ST_REVIEW    = 5'd18;
    localparam logic [4:0] ST_BREAK     = 5'd19;
    localparam logic [4:0] ST_SNACK     = 5'd20;
    localparam logic [4:0] ST_IDLEWRITE = 5'd21;

    // One bit per state code: states that award a motivation point
    localparam logic [31:0] c_reward_mask =
        (32'd1 << ST_STUDY) | (32'd1 << ST_EXERCISE) | (32'd1 << ST_SLEEP) |
        (32'd1 << ST_HELP)  | (32'd1 << ST_READ)     | (32'd1 << ST_PRACTICE) |
        (32'd1 << ST_REVIEW);

    // One bit per state code: states that present a decision prompt
    localparam logic [31:0] c_prompt_mask =
        (32'd1 << ST_START)    | (32'd1 << ST_CHOICE_A) | (32'd1 << ST_CHOICE_B) |
        (32'd1 << ST_CHOICE_C) | (32'd1 << ST_CHOICE_D);

    // Ending codes
    localparam logic [4:0] c_end_win    = ST_SUCCESS;
    localparam logic [4:0] c_end_lose_a = ST_DROPOUT;
    localparam logic [4:0] c_end_lose_b = ST_BURNOUT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WON  = 2'd2,
        LOST = 2'd3
    } score_st_t;

    function automatic logic in_mask(input logic [31:0] mask, input logic [4:0] code);
        return mask[code];
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : game_scoreboard_if
//  Purpose  : Bundle between the Game FSM side (master: drives state) and the
//             scoreboard (slave: returns score/status outputs).
//  Signals  : state, motivation, plus_one, repeat_hit, turns, done,
//             success, mismatch
//  Revision : 1.0 - initial release
// ============================================================================
interface game_scoreboard_if #(
    parameter int STATE_W = 5,
    parameter int MOT_W   = 4,
    parameter int TURN_W  = 8
);
    logic [STATE_W-1:0] state;
    logic [MOT_W-1:0]   motivation;
    logic               plus_one;
    logic               repeat_hit;
    logic [TURN_W-1:0]  turns;
    logic               done;
    logic               success;
    logic               mismatch;

    modport master (
        output state,
        input  motivation, plus_one, repeat_hit, turns, done, success, mismatch
    );

    modport slave (
        input  state,
        output motivation, plus_one, repeat_hit, turns, done, success, mismatch
    );
endinterface
`default_nettype wire

// File: rtl/game_entry_detect.sv
`default_nettype none
// ============================================================================
//  Module   : game_entry_detect
//  Purpose  : Remembers the previously sampled state code and flags a state
//             entry whenever the current code differs from it.
//  Ports    : clk, reset (async, active-low), state (in),
//             entry (out, combinational), entry_code (out)
//  Revision : 1.0 - initial release
// ============================================================================
module game_entry_detect #(
    parameter int STATE_W = 5
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [STATE_W-1:0] state,
    output logic                    entry,
    output logic [STATE_W-1:0]      entry_code
);
    logic [STATE_W-1:0] r_prev;

    // r_prev clears to 0 so the first nonzero code after reset is an entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_prev <= '0;
        else        r_prev <= state;
    end

    assign entry      = (state != r_prev);
    assign entry_code = state;
endmodule
`default_nettype wire

// File: rtl/game_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : game_scoreboard
//  Purpose  : Watches the Game state code, awards one motivation point per
//             distinct reward state, counts prompt entries and classifies
//             the run as won or lost at the first ending state.
//  Ports    : clk, reset (async, active-low), sb (game_scoreboard_if.slave):
//             state in; motivation, plus_one, repeat_hit, turns, done,
//             success, mismatch out (all registered)
//  Options  : GAME_SCORE_CHECK_EN - enables the sticky mismatch flag that
//             catches endings inconsistent with the motivation reached.
//  Revision : 1.0 - initial release
// ============================================================================
module game_scoreboard
    import game_pkg::*;
#(
    parameter int STATE_W = 5,
    parameter int MOT_W   = 4,
    parameter int GOAL    = 4,
    parameter int TURN_W  = 8
) (
    input wire logic    clk,
    input wire logic    reset,
    game_scoreboard_if.slave sb
);
    localparam logic [MOT_W-1:0] c_goal = MOT_W'(GOAL);

    logic               w_entry;
    logic [STATE_W-1:0] w_code;
    logic [4:0]         w_code5;
    logic               w_live;

    score_st_t          r_state;
    logic [MOT_W-1:0]   r_mot;
    logic               r_plus;
    logic               r_rep;
    logic [TURN_W-1:0]  r_turns;
    logic               r_done;
    logic               r_succ;
    logic [31:0]        r_visited;

    game_entry_detect #(.STATE_W(STATE_W)) u_entry (
        .clk        (clk),
        .reset      (reset),
        .state      (sb.state),
        .entry      (w_entry),
        .entry_code (w_code)
    );

    assign w_code5 = w_code[4:0];
    // Entries only matter before an ending has been reached
    assign w_live  = w_entry && (r_state == IDLE || r_state == PLAY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_mot     <= '0;
            r_plus    <= 1'b0;
            r_rep     <= 1'b0;
            r_turns   <= '0;
            r_done    <= 1'b0;
            r_succ    <= 1'b0;
            r_visited <= '0;
        end else begin
            r_plus <= 1'b0;
            r_rep  <= 1'b0;
            if (w_live) begin
                // A first visit still pulses and marks the state even when
                // the counter is already saturated
                if (in_mask(c_reward_mask, w_code5) && !r_visited[w_code5]) begin
                    r_visited[w_code5] <= 1'b1;
                    r_plus             <= 1'b1;
                    if (r_mot != '1) r_mot <= r_mot + MOT_W'(1);
                end
                if (w_code5 == ST_REPEAT) r_rep <= 1'b1;
                if (in_mask(c_prompt_mask, w_code5) && (r_turns != '1))
                    r_turns <= r_turns + TURN_W'(1);

                // Endings are honoured from IDLE too
                if (w_code5 == c_end_win) begin
                    r_state <= WON;
                    r_done  <= 1'b1;
                    r_succ  <= 1'b1;
                end else if (w_code5 == c_end_lose_a || w_code5 == c_end_lose_b) begin
                    r_state <= LOST;
                    r_done  <= 1'b1;
                end else if (r_state == IDLE && w_code5 != 5'd0) begin
                    r_state <= PLAY;
                end
            end
        end
    end

`ifdef GAME_SCORE_CHECK_EN
    logic r_mis;
    logic w_bad;

    // Winning below the goal or dropping out at/above it is inconsistent
    assign w_bad = w_live &&
                   (((w_code5 == c_end_win)    && (r_mot <  c_goal)) ||
                    ((w_code5 == c_end_lose_a) && (r_mot >= c_goal)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mis <= 1'b0;
        end else begin
            if (w_bad) r_mis <= 1'b1;
            assert (!w_bad)
                else $warning("game_scoreboard: inconsistent ending code %0d", w_code5);
        end
    end

    assign sb.mismatch = r_mis;
`else
    assign sb.mismatch = 1'b0;
`endif

    assign sb.motivation = r_mot;
    assign sb.plus_one   = r_plus;
    assign sb.repeat_hit = r_rep;
    assign sb.turns      = r_turns;
    assign sb.done       = r_done;
    assign sb.success    = r_succ;
endmodule
`default_nettype wire
